// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding and
// the sequential PC increment.
package fetch_pkg;

    localparam int unsigned PC_INCR = 4;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        SKID  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: holds one fetched instruction with its address and
// address + increment. Flush beats load, and load beats consume.
module if_id_reg #(
    parameter int unsigned W    = 32,
    parameter int unsigned INCR = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         flush_i,
    input  logic         load_i,
    input  logic         consume_i,
    input  logic [W-1:0] instr_i,
    input  logic [W-1:0] pc_i,
    output logic         valid_o,
    output logic [W-1:0] instr_o,
    output logic [W-1:0] pc_o,
    output logic [W-1:0] pc_plus_o
);

    logic         valid_q;
    logic [W-1:0] instr_q;
    logic [W-1:0] pc_q;
    logic [W-1:0] pc_plus_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            pc_q      <= '0;
            pc_plus_q <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q   <= 1'b1;
                instr_q   <= instr_i;
                pc_q      <= pc_i;
                pc_plus_q <= pc_i + W'(INCR);
            end else if (consume_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pc_plus_o = pc_plus_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues req/ack reads at PC, fills IF/ID, and holds
// the program counter via PC_STALL until a fetch is accepted or a redirect occurs.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned data_size = 32,
    parameter int unsigned pc_incr   = PC_INCR
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [data_size-1:0] PC,
    output logic                 PC_STALL,
    output logic                 IMEM_REQ,
    output logic [data_size-1:0] IMEM_ADDR,
    input  logic                 IMEM_ACK,
    input  logic [data_size-1:0] IMEM_RDATA,
    input  logic                 ID_STALL,
    input  logic                 FLUSH,
    output logic                 IFID_VALID,
    output logic [data_size-1:0] IFID_INSTR,
    output logic [data_size-1:0] IFID_PC,
    output logic [data_size-1:0] IFID_PC_PLUS
);

    fetch_state_e         state_q, state_d;
    logic                 req_q, req_d;
    logic [data_size-1:0] addr_q, addr_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [data_size-1:0] skid_instr_q, skid_instr_d;
    logic [data_size-1:0] skid_pc_q, skid_pc_d;

    logic                 load;
    logic [data_size-1:0] load_instr;
    logic [data_size-1:0] load_pc;
    logic                 ifid_valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ISSUE;
            req_q        <= 1'b0;
            addr_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // NOTE: skid payload is only ever read while skid_valid_q is set, so it
    // needs no reset and stays a plain data register.
    always_ff @(posedge CLK) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        load         = 1'b0;
        load_instr   = IMEM_RDATA;
        load_pc      = addr_q;

        unique case (state_q)
            ISSUE: begin
                if (!FLUSH) begin
                    req_d   = 1'b1;
                    addr_d  = PC;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (IMEM_ACK) begin
                    req_d   = 1'b0;
                    state_d = ISSUE;
                    if (!FLUSH) begin
                        if (!ifid_valid || !ID_STALL) begin
                            load = 1'b1;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_instr_d = IMEM_RDATA;
                            skid_pc_d    = addr_q;
                            state_d      = SKID;
                        end
                    end
                end else if (FLUSH) begin
                    state_d = DROP;
                end
            end
            // The memory handshake is always completed; the response is discarded.
            DROP: begin
                if (IMEM_ACK) begin
                    req_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            SKID: begin
                if (FLUSH) begin
                    skid_valid_d = 1'b0;
                    state_d      = ISSUE;
                end else if (!ID_STALL) begin
                    load         = 1'b1;
                    load_instr   = skid_instr_q;
                    load_pc      = skid_pc_q;
                    skid_valid_d = 1'b0;
                    state_d      = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // The skid case already advanced the PC when the data was accepted.
    assign PC_STALL  = !(FLUSH || (state_q == WAIT && IMEM_ACK));
    assign IMEM_REQ  = req_q;
    assign IMEM_ADDR = addr_q;

    if_id_reg #(
        .W    (data_size),
        .INCR (pc_incr)
    ) u_if_id_reg (
        .CLK       (CLK),
        .RST       (RST),
        .flush_i   (FLUSH),
        .load_i    (load),
        .consume_i (ifid_valid && !ID_STALL),
        .instr_i   (load_instr),
        .pc_i      (load_pc),
        .valid_o   (ifid_valid),
        .instr_o   (IFID_INSTR),
        .pc_o      (IFID_PC),
        .pc_plus_o (IFID_PC_PLUS)
    );

    assign IFID_VALID = ifid_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] PC;
    logic        PC_STALL;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic        ID_STALL;
    logic        FLUSH;
    logic        IFID_VALID;
    logic [31:0] IFID_INSTR;
    logic [31:0] IFID_PC;
    logic [31:0] IFID_PC_PLUS;

    int n_total = 0;
    int n_bad   = 0;

    fetch_unit #(
        .data_size (32),
        .pc_incr   (4)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .PC           (PC),
        .PC_STALL     (PC_STALL),
        .IMEM_REQ     (IMEM_REQ),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_ACK     (IMEM_ACK),
        .IMEM_RDATA   (IMEM_RDATA),
        .ID_STALL     (ID_STALL),
        .FLUSH        (FLUSH),
        .IFID_VALID   (IFID_VALID),
        .IFID_INSTR   (IFID_INSTR),
        .IFID_PC      (IFID_PC),
        .IFID_PC_PLUS (IFID_PC_PLUS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST        = 1'b0;
        PC         = '0;
        IMEM_ACK   = 1'b0;
        IMEM_RDATA = '0;
        ID_STALL   = 1'b0;
        FLUSH      = 1'b0;
        cyc();
        RST = 1'b1;
    endtask

    // Issue at pc, ack one cycle after the request edge, then load into IF/ID.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
        PC = pc;
        cyc();
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = data;
        cyc();
        IMEM_ACK = 1'b0;
        PC       = pc + 32'd4;
    endtask

    initial begin
        RST        = 1'b1;
        PC         = '0;
        IMEM_ACK   = 1'b0;
        IMEM_RDATA = '0;
        ID_STALL   = 1'b0;
        FLUSH      = 1'b0;
        #2 RST = 1'b0;
        #1;
        check("rst_req",   IMEM_REQ,     32'd0);
        check("rst_addr",  IMEM_ADDR,    32'd0);
        check("rst_valid", IFID_VALID,   32'd0);
        check("rst_instr", IFID_INSTR,   32'd0);
        check("rst_pc",    IFID_PC,      32'd0);
        check("rst_plus",  IFID_PC_PLUS, 32'd0);
        check("rst_stall", PC_STALL,     32'd1);
        cyc();

        // Single fetch, ack two cycles after the request.
        RST = 1'b1;
        PC  = 32'h100;
        cyc();
        check("t1_req",   IMEM_REQ,  32'd1);
        check("t1_addr",  IMEM_ADDR, 32'h100);
        check("t1_stall_wait", PC_STALL, 32'd1);
        cyc();
        check("t1_stall_wait2", PC_STALL, 32'd1);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'h2002_0005;
        #1 check("t1_stall_ack", PC_STALL, 32'd0);
        cyc();
        IMEM_ACK = 1'b0;
        PC       = 32'h104;
        #1;
        check("t1_valid", IFID_VALID,   32'd1);
        check("t1_instr", IFID_INSTR,   32'h2002_0005);
        check("t1_pc",    IFID_PC,      32'h100);
        check("t1_plus",  IFID_PC_PLUS, 32'h104);
        check("t1_req_lo", IMEM_REQ,    32'd0);
        check("t1_stall_after", PC_STALL, 32'd1);

        // Back-to-back fetches, ack latency 1.
        do_reset();
        PC = 32'h0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_req%0d", i),  IMEM_REQ,  32'd1);
            check($sformatf("b2b_addr%0d", i), IMEM_ADDR, 32'(4 * i));
            check($sformatf("b2b_vlo%0d", i),  IFID_VALID, 32'd0);
            IMEM_ACK   = 1'b1;
            IMEM_RDATA = 32'hA0 + 32'(i);
            #1 check($sformatf("b2b_stall%0d", i), PC_STALL, 32'd0);
            cyc();
            IMEM_ACK = 1'b0;
            PC       = 32'(4 * (i + 1));
            check($sformatf("b2b_valid%0d", i), IFID_VALID, 32'd1);
            check($sformatf("b2b_pc%0d", i),    IFID_PC,    32'(4 * i));
            check($sformatf("b2b_instr%0d", i), IFID_INSTR, 32'hA0 + 32'(i));
            check($sformatf("b2b_reqlo%0d", i), IMEM_REQ,   32'd0);
            cyc();
        end

        // Skid: IF/ID holds 0x1C under ID_STALL when the ack for 0x20 arrives.
        do_reset();
        fetch_one(32'h1C, 32'h11);
        ID_STALL = 1'b1;
        check("sk_valid0", IFID_VALID, 32'd1);
        cyc();
        check("sk_req",  IMEM_REQ,  32'd1);
        check("sk_addr", IMEM_ADDR, 32'h20);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'h55;
        #1 check("sk_stall_ack", PC_STALL, 32'd0);
        cyc();
        IMEM_ACK = 1'b0;
        PC       = 32'h24;
        check("sk_req_lo", IMEM_REQ, 32'd0);
        check("sk_hold_pc", IFID_PC, 32'h1C);
        check("sk_hold_v",  IFID_VALID, 32'd1);
        cyc();
        check("sk_req_lo2", IMEM_REQ, 32'd0);
        check("sk_stall_hold", PC_STALL, 32'd1);
        ID_STALL = 1'b0;
        cyc();
        check("sk_ld_valid", IFID_VALID,   32'd1);
        check("sk_ld_pc",    IFID_PC,      32'h20);
        check("sk_ld_instr", IFID_INSTR,   32'h55);
        check("sk_ld_plus",  IFID_PC_PLUS, 32'h24);
        check("sk_ld_req",   IMEM_REQ,     32'd0);
        cyc();
        check("sk_next_req",  IMEM_REQ,  32'd1);
        check("sk_next_addr", IMEM_ADDR, 32'h24);

        // Flush while waiting: request to 0x40 held until its ack, then dropped.
        do_reset();
        PC = 32'h40;
        cyc();
        FLUSH = 1'b1;
        #1 check("fw_stall_flush", PC_STALL, 32'd0);
        cyc();
        FLUSH = 1'b0;
        PC    = 32'h80;
        check("fw_req1",  IMEM_REQ,  32'd1);
        check("fw_addr1", IMEM_ADDR, 32'h40);
        cyc();
        check("fw_req2",  IMEM_REQ,  32'd1);
        check("fw_addr2", IMEM_ADDR, 32'h40);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'hDEAD;
        #1 check("fw_stall_drop", PC_STALL, 32'd1);
        cyc();
        IMEM_ACK = 1'b0;
        check("fw_valid", IFID_VALID, 32'd0);
        check("fw_reqlo", IMEM_REQ,   32'd0);
        cyc();
        check("fw_new_req",  IMEM_REQ,  32'd1);
        check("fw_new_addr", IMEM_ADDR, 32'h80);
        check("fw_valid2",   IFID_VALID, 32'd0);

        // Flush coincident with ack.
        do_reset();
        PC = 32'h60;
        cyc();
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'hBAD;
        FLUSH      = 1'b1;
        #1 check("fa_stall", PC_STALL, 32'd0);
        cyc();
        IMEM_ACK = 1'b0;
        FLUSH    = 1'b0;
        PC       = 32'h90;
        check("fa_valid", IFID_VALID, 32'd0);
        check("fa_reqlo", IMEM_REQ,   32'd0);
        cyc();
        check("fa_req",  IMEM_REQ,  32'd1);
        check("fa_addr", IMEM_ADDR, 32'h90);

        // Flush while in SKID discards both IF/ID and the buffered word.
        do_reset();
        fetch_one(32'h70, 32'h70);
        ID_STALL = 1'b1;
        cyc();
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'h77;
        cyc();
        IMEM_ACK = 1'b0;
        PC       = 32'h78;
        check("fs_skid_reqlo", IMEM_REQ, 32'd0);
        FLUSH = 1'b1;
        #1 check("fs_stall", PC_STALL, 32'd0);
        cyc();
        FLUSH    = 1'b0;
        ID_STALL = 1'b0;
        PC       = 32'hC0;
        check("fs_valid", IFID_VALID, 32'd0);
        cyc();
        check("fs_req",    IMEM_REQ,   32'd1);
        check("fs_addr",   IMEM_ADDR,  32'hC0);
        check("fs_valid2", IFID_VALID, 32'd0);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'hC0C0;
        cyc();
        IMEM_ACK = 1'b0;
        check("fs_ld_pc",    IFID_PC,    32'hC0);
        check("fs_ld_instr", IFID_INSTR, 32'hC0C0);

        // Reset mid-request with IF/ID valid, then wrap-around fetch.
        do_reset();
        fetch_one(32'h10, 32'h99);
        ID_STALL = 1'b1;
        cyc();
        check("rm_pre_req",   IMEM_REQ,   32'd1);
        check("rm_pre_valid", IFID_VALID, 32'd1);
        RST = 1'b0;
        #1;
        check("rm_req",   IMEM_REQ,     32'd0);
        check("rm_addr",  IMEM_ADDR,    32'd0);
        check("rm_valid", IFID_VALID,   32'd0);
        check("rm_instr", IFID_INSTR,   32'd0);
        check("rm_pc",    IFID_PC,      32'd0);
        check("rm_plus",  IFID_PC_PLUS, 32'd0);
        cyc();
        RST      = 1'b1;
        ID_STALL = 1'b0;
        PC       = 32'hFFFF_FFFC;
        cyc();
        check("wr_req",  IMEM_REQ,  32'd1);
        check("wr_addr", IMEM_ADDR, 32'hFFFF_FFFC);
        IMEM_ACK   = 1'b1;
        IMEM_RDATA = 32'h1234;
        cyc();
        IMEM_ACK = 1'b0;
        check("wr_valid", IFID_VALID,   32'd1);
        check("wr_pc",    IFID_PC,      32'hFFFF_FFFC);
        check("wr_plus",  IFID_PC_PLUS, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
